// File: rtl/vram_pkg.sv
// Shared types for the video RAM arbiter.
// Optional posted-write buffer: VRAM_WRITE_BUFFER_EN.
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RD1  = 2'd1,
    C_RD2  = 2'd2,
    C_WR   = 2'd3
  } cstate_e;

endpackage

// File: rtl/vram_write_buffer.sv
// One-entry posted CPU write buffer.
// Only instantiated when VRAM_WRITE_BUFFER_EN is defined.
module vram_write_buffer
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              drain_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    full_d  = full_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load_i) begin
      full_d  = 1'b1;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      full_q  <= full_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign full_o  = full_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: video fetch priority, CPU req/ack.
// Define VRAM_WRITE_BUFFER_EN for the posted write buffer.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic [DATA_W-1:0] vid_data_o,
  output logic              vid_valid_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  cstate_e           state_q, state_d;
  tag_e              tag1_q, tag1_d;
  tag_e              tag2_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;

  logic              cpu_ok;
  logic              buf_full;
  logic              buf_load;
  logic              buf_drain;

`ifdef VRAM_WRITE_BUFFER_EN
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;

  vram_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .addr_i  (cpu_addr_i),
    .wdata_i (cpu_wdata_i),
    .drain_i (buf_drain),
    .full_o  (buf_full),
    .addr_o  (buf_addr),
    .wdata_o (buf_wdata)
  );
`else
  assign buf_full = 1'b0;
`endif

  // New CPU work waits for a full buffer to drain (keeps order).
  assign cpu_ok = (state_q == C_IDLE) && cpu_req_i && !buf_full;

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = TAG_NONE;
    buf_drain   = 1'b0;
    if (vid_req_i) begin
      ram_addr_d = vid_addr_i;
      tag1_d     = TAG_VID;
`ifdef VRAM_WRITE_BUFFER_EN
    end else if (buf_full) begin
      ram_addr_d  = buf_addr;
      ram_we_d    = 1'b1;
      ram_wdata_d = buf_wdata;
      buf_drain   = 1'b1;
`endif
    end else if (cpu_ok) begin
      ram_addr_d = cpu_addr_i;
      if (cpu_we_i) begin
        ram_we_d    = 1'b1;
        ram_wdata_d = cpu_wdata_i;
      end else begin
        tag1_d = TAG_CPU;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_ack_d = 1'b0;
    buf_load  = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (cpu_ok && !vid_req_i) begin
          state_d = cpu_we_i ? C_WR : C_RD1;
        end else if (cpu_ok && cpu_we_i) begin
`ifdef VRAM_WRITE_BUFFER_EN
          buf_load = 1'b1;
          state_d  = C_WR;
`endif
        end
      end
      C_RD1: state_d = C_RD2;
      C_RD2: begin
        state_d   = C_IDLE;
        cpu_ack_d = 1'b1;
      end
      C_WR: begin
        state_d   = C_IDLE;
        cpu_ack_d = 1'b1;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // tag2_q names the owner of the data on ram_rdata_i now.
  always_comb begin
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    unique case (tag2_q)
      TAG_VID: begin
        vid_data_d  = ram_rdata_i;
        vid_valid_d = 1'b1;
      end
      TAG_CPU: cpu_rdata_d = ram_rdata_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= C_IDLE;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;
  assign vid_data_o  = vid_data_q;
  assign vid_valid_o = vid_valid_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single-port 8 KB video RAM between the VGA scan-out fetcher and the CPU bus. Video reads have absolute priority and a fixed latency so the 1 bpp scan-out never starves. CPU reads and writes use a req/ack handshake and fill the free RAM slots. Sits between the VGA block, the CPU bus interface and the video RAM macro, in the 130 MHz (2×65 MHz) pixel clock domain.

## Interface
- ADDR_W, 13: RAM address width (8 KB).
- DATA_W, 8: RAM data width.
- clk  in  1  2× pixel clock (130 MHz).
- reset  in  1  synchronous, active-high.
- vid_req  in  1  one-cycle video fetch strobe.
- vid_addr  in  ADDR_W  video fetch address, valid with vid_req.
- vid_data  out  DATA_W  fetched video byte, held until next video fetch.
- vid_valid  out  1  one-cycle pulse when vid_data updates.
- cpu_req  in  1  CPU transaction request, level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req.
- cpu_rdata  out  DATA_W  read data, valid with cpu_ack on reads.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr (synchronous read).

## Operation
- One RAM access issued per clock edge at most; access issued at edge n appears on ram_* after n.
- Priority: vid_req at edge n is always issued at n. CPU transaction issued at edge n only if vid_req=0 at n and CPU FSM is C_IDLE with cpu_req=1.
- Usage constraint: vid_req never asserted on two consecutive edges; the VGA fetcher issues once per 16 clocks.
- Read-return pipeline carries a 2-bit tag (none/video/cpu) alongside each issued access; returned data routed by tag.
- CPU FSM: C_IDLE → (issue read) C_RD1 → C_RD2 → C_IDLE with cpu_ack; C_IDLE → (issue write) C_WR → C_IDLE with cpu_ack. cpu_req sampled again in C_IDLE the edge after cpu_ack; back-to-back transactions allowed with req held high.
- vid_data updated only on video returns; CPU returns never disturb it.
- Idle RAM: ram_we=0, ram_addr holds last value.
- Reset mid-transaction: pipeline tags cleared, FSM to C_IDLE, no ack/valid issued for in-flight accesses; in-flight write may or may not have reached RAM.
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0.

## Timing
- Video read: vid_req at edge n → ram_addr at n → ram_rdata valid after n+1 → vid_data/vid_valid registered at n+2 (fixed, 2-edge latency, never stalled).
- CPU read unblocked: cpu_req seen at n → cpu_ack, cpu_rdata at n+2. Blocked by vid_req: +1 edge.
- CPU write unblocked: issued at n → cpu_ack at n+1. Blocked: +1 edge.
- Simultaneous vid_req and cpu_req: video issued, CPU issued at next edge.
- Worst-case CPU read latency 3 edges, write 2 edges (without write buffer).

## Configuration
- VRAM_WRITE_BUFFER_EN defined: one-entry posted write buffer. CPU write acked at edge n+1 after sampling regardless of video conflict; buffer drains into first free slot. CPU read or second write while buffer full waits until drained (program order kept). Reset empties buffer, discarding content.
- Undefined: writes issued directly per the timing above; no buffer logic.

## Structure
- Package vram_pkg: ADDR_W/DATA_W defaults, tag enum (TAG_NONE, TAG_VID, TAG_CPU), CPU FSM state enum.
- Sub-module vram_write_buffer (entry register, full flag, drain handshake), instantiated only under VRAM_WRITE_BUFFER_EN.

## Test plan
- Video only: vid_req every 16 clocks, RAM preloaded addr 0x0123=0x5A → vid_valid 2 edges later, vid_data=0x5A, no cpu_ack.
- CPU read unblocked: cpu_req, cpu_we=0, addr 0x1FFF=0xC3 → cpu_ack, cpu_rdata=0xC3 at n+2, exactly one ack pulse.
- Collision: vid_req(0x0010) and cpu write (0x0020, 0xA5) same edge → ram_addr=0x0010 first, 0x0020 with ram_we=1 next edge; cpu_ack at n+2; vid_data unaffected.
- Back-to-back CPU: write 0x0100=0x77 then read 0x0100 with req held → read returns 0x77, two ack pulses.
- Reset mid-read: reset asserted the edge after CPU read issue → no cpu_ack, all outputs at reset values next edge.
- With VRAM_WRITE_BUFFER_EN: write during vid_req → cpu_ack at n+1, RAM write one edge later; immediate read of same address returns new data.
